// File: rtl/hilo_ctrl.sv
// hilo_ctrl: EX-stage HI/LO controller for multiply/divide.
// Starts the iterative multiplier (and the divider when HILO_DIV_EN is
// defined), stalls EX until the unit reports ready, then writes HI/LO.
// Also performs MTHI/MTLO writes and drives the MFHI/MFLO read data.
// Optional feature macro: HILO_DIV_EN (divider ports and DIV_WAIT state).
// Without HILO_DIV_EN, DIV/DIVU take one cycle, do not stall, and leave
// HI/LO unchanged.
module hilo_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic [3:0]  ex_op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        mul_start_o,
  output logic        mul_signed_o,
  output logic [31:0] mul_a_o,
  output logic [31:0] mul_b_o,
  input  logic [63:0] mul_result_i,
  input  logic        mul_ready_i,
`ifdef HILO_DIV_EN
  output logic        div_start_o,
  output logic        div_signed_o,
  output logic [31:0] div_a_o,
  output logic [31:0] div_b_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
`endif
  output logic [31:0] mf_data_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
`ifdef HILO_DIV_EN
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
`endif
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

`ifdef HILO_DIV_EN
  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT} state_e;
`else
  typedef enum logic [1:0] {IDLE, MUL_WAIT} state_e;
`endif

  state_e      state_q, state_d;
  logic        issue_ok;
  logic        is_mul;
  logic        mul_start_d, mul_signed_d;
  logic [31:0] mul_a_d, mul_b_d;
  logic [31:0] hi_d, lo_d;
`ifdef HILO_DIV_EN
  logic        is_div;
  logic        div_start_d, div_signed_d;
  logic [31:0] div_a_d, div_b_d;
`endif

  // Decode helpers: an instruction may only act in IDLE and when not killed.
  assign issue_ok = (state_q == IDLE) && ex_valid_i && !flush_i;
  assign is_mul   = (ex_op_i == OP_MULT) || (ex_op_i == OP_MULTU);
`ifdef HILO_DIV_EN
  assign is_div   = (ex_op_i == OP_DIV) || (ex_op_i == OP_DIVU);
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, next register values and the combinational stall.
  // Ready is only looked at in the wait states, so the unit's ready that
  // lingers into the first IDLE cycle cannot cause a second HI/LO write.
  always_comb begin
    state_d      = state_q;
    stall_o      = 1'b0;
    mul_start_d  = mul_start_o;
    mul_signed_d = mul_signed_o;
    mul_a_d      = mul_a_o;
    mul_b_d      = mul_b_o;
    hi_d         = hi_o;
    lo_d         = lo_o;
`ifdef HILO_DIV_EN
    div_start_d  = div_start_o;
    div_signed_d = div_signed_o;
    div_a_d      = div_a_o;
    div_b_d      = div_b_o;
`endif
    case (state_q)
      IDLE: begin
        if (issue_ok) begin
          if (is_mul) begin
            stall_o      = 1'b1;
            mul_start_d  = 1'b1;
            mul_signed_d = (ex_op_i == OP_MULT);
            mul_a_d      = rs_i;
            mul_b_d      = rt_i;
            state_d      = MUL_WAIT;
          end
`ifdef HILO_DIV_EN
          else if (is_div) begin
            stall_o      = 1'b1;
            div_start_d  = 1'b1;
            div_signed_d = (ex_op_i == OP_DIV);
            div_a_d      = rs_i;
            div_b_d      = rt_i;
            state_d      = DIV_WAIT;
          end
`endif
          else if (ex_op_i == OP_MTHI) begin
            hi_d = rs_i;
          end else if (ex_op_i == OP_MTLO) begin
            lo_d = rs_i;
          end
        end
      end
      MUL_WAIT: begin
        if (flush_i) begin
          mul_start_d = 1'b0;
          state_d     = IDLE;
        end else if (mul_ready_i) begin
          hi_d        = mul_result_i[63:32];
          lo_d        = mul_result_i[31:0];
          mul_start_d = 1'b0;
          state_d     = IDLE;
        end else begin
          stall_o = 1'b1;
        end
      end
`ifdef HILO_DIV_EN
      DIV_WAIT: begin
        if (flush_i) begin
          div_start_d = 1'b0;
          state_d     = IDLE;
        end else if (div_ready_i) begin
          hi_d        = div_result_i[63:32];
          lo_d        = div_result_i[31:0];
          div_start_d = 1'b0;
          state_d     = IDLE;
        end else begin
          stall_o = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Unit request and architectural HI/LO registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_start_o  <= 1'b0;
      mul_signed_o <= 1'b0;
      mul_a_o      <= '0;
      mul_b_o      <= '0;
      hi_o         <= '0;
      lo_o         <= '0;
`ifdef HILO_DIV_EN
      div_start_o  <= 1'b0;
      div_signed_o <= 1'b0;
      div_a_o      <= '0;
      div_b_o      <= '0;
`endif
    end else begin
      mul_start_o  <= mul_start_d;
      mul_signed_o <= mul_signed_d;
      mul_a_o      <= mul_a_d;
      mul_b_o      <= mul_b_d;
      hi_o         <= hi_d;
      lo_o         <= lo_d;
`ifdef HILO_DIV_EN
      div_start_o  <= div_start_d;
      div_signed_o <= div_signed_d;
      div_a_o      <= div_a_d;
      div_b_o      <= div_b_d;
`endif
    end
  end

  // MFHI/MFLO read data straight from the architectural registers.
  always_comb begin
    mf_data_o = '0;
    if (ex_valid_i && (ex_op_i == OP_MFHI))      mf_data_o = hi_o;
    else if (ex_valid_i && (ex_op_i == OP_MFLO)) mf_data_o = lo_o;
  end

endmodule

// File: doc/hilo_ctrl.md
# hilo_ctrl

EX-stage controller for HI/LO multiply/divide operations. It decodes the mul/div class of instructions, launches the iterative multiplier (and optionally the divider), and stalls the pipeline until the result is ready. It then captures the 64-bit product or quotient/remainder into the architectural HI/LO registers and serves MFHI/MFLO reads. It sits between the EX decode path and the multi-cycle `mul` block, driving its start/operand inputs and consuming `result_o`/`ready_o`.

## Interface

Parameters:
- none

Ports:
- `clk` input 1 – system clock, rising edge.
- `rst` input 1 – asynchronous, active-high reset.
- `ex_valid_i` input 1 – EX holds a valid instruction this cycle.
- `ex_op_i` input 4 – 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; 9–15 are treated as NOP.
- `rs_i`, `rt_i` input 32 each – source operands.
- `flush_i` input 1 – kill the EX instruction.
- `stall_o` output 1 – hold the pipeline at EX and earlier.
- `mul_start_o`, `mul_signed_o` output 1 each; `mul_a_o`, `mul_b_o` output 32 each – multiplier request.
- `mul_result_i` input 64; `mul_ready_i` input 1 – multiplier response.
- `div_start_o`, `div_signed_o` output 1 each; `div_a_o`, `div_b_o` output 32 each; `div_result_i` input 64, {rem, quot}; `div_ready_i` input 1. These exist only with `HILO_DIV_EN`.
- `mf_data_o` output 32 – HI for MFHI, LO for MFLO, 0 otherwise. Combinational.
- `hi_o`, `lo_o` output 32 each – architectural HI/LO.

## Operation

- States:
  - IDLE, MUL_WAIT, DIV_WAIT.
  - Reset forces IDLE.
  - All outputs reset to 0; `hi_o`/`lo_o` reset to 0x0.
- IDLE, MULT/MULTU with `ex_valid_i` and no `flush_i`:
  - Latch `rs_i`→`mul_a_o`, `rt_i`→`mul_b_o`.
  - `mul_signed_o` = (op==MULT).
  - Set `mul_start_o`=1 at the next edge and go to MUL_WAIT.
- IDLE, DIV/DIVU: same as MULT/MULTU, using the div ports and going to DIV_WAIT.
- MUL_WAIT:
  - Hold `mul_start_o`=1 and the operands stable.
  - When `mul_ready_i`=1: HI←`mul_result_i[63:32]`, LO←`mul_result_i[31:0]`; drop `mul_start_o` at the same edge; go to IDLE.
- DIV_WAIT:
  - When `div_ready_i`=1: LO←quotient `[31:0]`, HI←remainder `[63:32]`; drop `div_start_o`; go to IDLE.
- IDLE ignores `mul_ready_i`/`div_ready_i`. The multiplier's ready is still high on the first IDLE cycle and must not cause a second write.
- MTHI/MTLO in IDLE: HI (or LO) ← `rs_i` at the edge. No stall.
- MFHI/MFLO: read the current registers. The register write of a completing MULT happens at the edge before the next instruction reaches EX, so no bypass is required.
- `flush_i` in MUL_WAIT/DIV_WAIT: drop start, go to IDLE, leave HI/LO unchanged, and ignore the late ready.
- `flush_i` in IDLE: suppresses any issue or MT write this cycle.
- An asynchronous `rst` mid-operation clears state, start and HI/LO immediately.

## Timing

- `stall_o` is combinational:
  - 1 in IDLE when a valid MULT/MULTU/DIV/DIVU is presented (issue cycle).
  - 1 in MUL_WAIT/DIV_WAIT while the ready input is 0.
  - 0 in the cycle the ready input is 1, so the instruction retires that edge.
- Total stall = issue cycle + multiplier latency (34 cycles for the 32-iteration `mul`).
- `hi_o`/`lo_o` update at the edge that ends the ready cycle.
- `mul_start_o` is low for at least one cycle between operations.
- A back-to-back MULT issues on the first IDLE cycle; its start reaches the multiplier after that block returns to its free state.

## Configuration

- `HILO_DIV_EN` defined:
  - The div ports and the DIV_WAIT state are present.
  - DIV/DIVU use the divider.
- `HILO_DIV_EN` undefined:
  - The div ports are absent.
  - DIV/DIVU complete in one cycle with no stall, leave HI/LO unchanged, and act as NOP.

## Test plan

- MULT with `rs`=0xFFFFFFFF, `rt`=0x00000002 (signed) → `mul_signed_o`=1; HI=0xFFFFFFFF, LO=0xFFFFFFFE; `stall_o` high until ready, then low for exactly one retire cycle.
- MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- MTHI 0x12345678, then MFHI next cycle → `mf_data_o`=0x12345678, no stall. MTLO 0xA5A5A5A5, then MFLO → `mf_data_o`=0xA5A5A5A5.
- MULT 3×5, then MULT 7×7 on the following cycle → the first result gives LO=0x0F and the second gives LO=0x31. Only two HI/LO writes occur, and `mul_start_o` is low for at least one cycle between them.
- `flush_i` pulsed 10 cycles into MUL_WAIT → start drops, state is IDLE, and HI/LO keep their prior values through the subsequent ready pulse.
- With `HILO_DIV_EN`: DIV 7 / −2 → LO=0xFFFFFFFD, HI=0x00000001. Without `HILO_DIV_EN`: DIV leaves HI/LO unchanged with zero stall. `rst` asserted mid-MUL_WAIT → all outputs 0 immediately.
